// File: rtl/bsg_axi_burst_master.sv
// bsg_axi_burst_master
//   Single-outstanding AXI4 burst master. Turns a valid/ready request
//   (address + write flag) into a fixed-length AXI write or read burst,
//   streams write words in and read words out, and pulses done_v_o with an
//   error flag once the burst completes.
//
// Configuration macro: BSG_AXI_BURST_MASTER_WRAP_EN
//   defined   : WRAP bursts, address aligned only to the data word
//               (critical-word-first)
//   undefined : INCR bursts, address aligned down to the burst boundary
//
// Ports
//   clk_i, reset_i            clock, synchronous active-high reset
//   req_*                     request channel (addr, write flag, valid/ready)
//   wdata_*, wstrb_i          write word stream into the master
//   rdata_*                   read word stream out of the master
//   done_v_o, done_err_o      one-cycle completion pulse and error flag
//   axi_aw*/w*/b*/ar*/r*      AXI4 master channels

module bsg_axi_burst_master #(
  parameter int axi_id_width_p    = 4,
  parameter int axi_addr_width_p  = 32,
  parameter int axi_data_width_p  = 64,
  parameter int axi_burst_len_p   = 4,
  parameter int axi_id_p          = 0,
  parameter int axi_strb_width_lp = axi_data_width_p >> 3
) (
  input  logic                          clk_i,
  input  logic                          reset_i,

  input  logic                          req_v_i,
  input  logic                          req_write_i,
  input  logic [axi_addr_width_p-1:0]   req_addr_i,
  output logic                          req_ready_o,

  input  logic                          wdata_v_i,
  input  logic [axi_data_width_p-1:0]   wdata_i,
  input  logic [axi_strb_width_lp-1:0]  wstrb_i,
  output logic                          wdata_ready_o,

  output logic                          rdata_v_o,
  output logic [axi_data_width_p-1:0]   rdata_o,
  output logic                          rdata_last_o,
  input  logic                          rdata_ready_i,

  output logic                          done_v_o,
  output logic                          done_err_o,

  output logic [axi_id_width_p-1:0]     axi_awid_o,
  output logic [axi_addr_width_p-1:0]   axi_awaddr_o,
  output logic [1:0]                    axi_awburst_o,
  output logic                          axi_awvalid_o,
  input  logic                          axi_awready_i,

  output logic [axi_data_width_p-1:0]   axi_wdata_o,
  output logic [axi_strb_width_lp-1:0]  axi_wstrb_o,
  output logic                          axi_wlast_o,
  output logic                          axi_wvalid_o,
  input  logic                          axi_wready_i,

  input  logic [axi_id_width_p-1:0]     axi_bid_i,
  input  logic [1:0]                    axi_bresp_i,
  input  logic                          axi_bvalid_i,
  output logic                          axi_bready_o,

  output logic [axi_id_width_p-1:0]     axi_arid_o,
  output logic [axi_addr_width_p-1:0]   axi_araddr_o,
  output logic [1:0]                    axi_arburst_o,
  output logic                          axi_arvalid_o,
  input  logic                          axi_arready_i,

  input  logic [axi_id_width_p-1:0]     axi_rid_i,
  input  logic [axi_data_width_p-1:0]   axi_rdata_i,
  input  logic [1:0]                    axi_rresp_i,
  input  logic                          axi_rlast_i,
  input  logic                          axi_rvalid_i,
  output logic                          axi_rready_o
);

  // Counter is at least one bit wide so a single-beat burst still builds.
  localparam int cnt_width_lp  = (axi_burst_len_p > 1) ? $clog2(axi_burst_len_p) : 1;
  localparam int word_bytes_lp = axi_data_width_p / 8;
  localparam logic [cnt_width_lp-1:0]   last_beat_lp = cnt_width_lp'(axi_burst_len_p - 1);
  localparam logic [axi_id_width_p-1:0] id_lp        = axi_id_width_p'(axi_id_p);

  typedef enum logic [2:0] {
    e_idle, e_wr_addr, e_wr_data, e_wr_resp, e_rd_addr, e_rd_data
  } state_e;

  state_e                        state_q, state_d;
  logic [axi_addr_width_p-1:0]   addr_q, addr_d;
  logic [cnt_width_lp-1:0]       cnt_q, cnt_d;
  logic                          err_q, err_d;
  logic [axi_addr_width_p-1:0]   req_addr_aligned;
  logic                          r_beat_err;
  logic [1:0]                    burst_type;

`ifdef BSG_AXI_BURST_MASTER_WRAP_EN
  localparam logic [axi_addr_width_p-1:0] word_mask_lp = ~axi_addr_width_p'(word_bytes_lp - 1);
  assign burst_type       = 2'b10;
  assign req_addr_aligned = req_addr_i & word_mask_lp;
`else
  // Modulo keeps the alignment correct for non-power-of-two burst lengths.
  localparam logic [axi_addr_width_p-1:0] burst_bytes_lp =
    axi_addr_width_p'(word_bytes_lp * axi_burst_len_p);
  assign burst_type       = 2'b01;
  assign req_addr_aligned = req_addr_i - (req_addr_i % burst_bytes_lp);
`endif

  assign axi_awid_o    = id_lp;
  assign axi_arid_o    = id_lp;
  assign axi_awaddr_o  = addr_q;
  assign axi_araddr_o  = addr_q;
  assign axi_awburst_o = burst_type;
  assign axi_arburst_o = burst_type;
  assign axi_wdata_o   = wdata_i;
  assign axi_wstrb_o   = wstrb_i;
  assign rdata_o       = axi_rdata_i;

  assign r_beat_err = (axi_rresp_i != 2'b00) | (axi_rid_i != id_lp);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= e_idle;
      addr_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    cnt_d         = cnt_q;
    err_d         = err_q;
    req_ready_o   = 1'b0;
    wdata_ready_o = 1'b0;
    rdata_v_o     = 1'b0;
    rdata_last_o  = 1'b0;
    done_v_o      = 1'b0;
    done_err_o    = 1'b0;
    axi_awvalid_o = 1'b0;
    axi_wvalid_o  = 1'b0;
    axi_wlast_o   = 1'b0;
    axi_bready_o  = 1'b0;
    axi_arvalid_o = 1'b0;
    axi_rready_o  = 1'b0;

    unique case (state_q)
      e_idle: begin
        req_ready_o = 1'b1;
        if (req_v_i) begin
          addr_d  = req_addr_aligned;
          cnt_d   = '0;
          err_d   = 1'b0;
          state_d = req_write_i ? e_wr_addr : e_rd_addr;
        end
      end
      e_wr_addr: begin
        axi_awvalid_o = 1'b1;
        if (axi_awready_i) state_d = e_wr_data;
      end
      e_wr_data: begin
        axi_wvalid_o  = wdata_v_i;
        wdata_ready_o = axi_wready_i;
        axi_wlast_o   = (cnt_q == last_beat_lp);
        if (wdata_v_i && axi_wready_i) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == last_beat_lp) state_d = e_wr_resp;
        end
      end
      e_wr_resp: begin
        axi_bready_o = 1'b1;
        if (axi_bvalid_i) begin
          done_v_o   = 1'b1;
          done_err_o = (axi_bresp_i != 2'b00) | (axi_bid_i != id_lp);
          state_d    = e_idle;
        end
      end
      e_rd_addr: begin
        axi_arvalid_o = 1'b1;
        if (axi_arready_i) state_d = e_rd_data;
      end
      e_rd_data: begin
        rdata_v_o    = axi_rvalid_i;
        axi_rready_o = rdata_ready_i;
        rdata_last_o = axi_rlast_i;
        if (axi_rvalid_i && rdata_ready_i) begin
          err_d = err_q | r_beat_err;
          if (axi_rlast_i) begin
            done_v_o   = 1'b1;
            done_err_o = err_q | r_beat_err;
            state_d    = e_idle;
          end
        end
      end
      default: state_d = e_idle;
    endcase

    // Nothing handshakes while reset is held, whatever state was left behind.
    if (reset_i) begin
      req_ready_o   = 1'b0;
      wdata_ready_o = 1'b0;
      rdata_v_o     = 1'b0;
      done_v_o      = 1'b0;
      done_err_o    = 1'b0;
      axi_awvalid_o = 1'b0;
      axi_wvalid_o  = 1'b0;
      axi_bready_o  = 1'b0;
      axi_arvalid_o = 1'b0;
      axi_rready_o  = 1'b0;
    end
  end

endmodule

// File: doc/bsg_axi_burst_master.md
# bsg_axi_burst_master

Non-synthesizable-bench-friendly but synthesizable AXI4 burst master sitting directly upstream of an AXI slave memory (e.g. the team's behavioural AXI memory model). Converts a simple valid/ready request interface (one address + write/read flag per request, fixed-length burst of data words) into single-outstanding AXI write or read bursts. Streams write data in, streams read data out, and reports per-transaction completion with an error flag.

## Interface
Parameters:
- axi_id_width_p, none (required), AXI ID width
- axi_addr_width_p, none (required), AXI address width
- axi_data_width_p, none (required), data width; multiple of 8, power of 2
- axi_burst_len_p, none (required), beats per burst, ≥1
- axi_id_p, 0, constant ID driven on awid/arid and expected on bid/rid
- axi_strb_width_lp, axi_data_width_p>>3, derived

Ports:
- clk_i  in  1  clock
- reset_i  in  1  reset; synchronous, active-high
- req_v_i  in  1  request valid
- req_write_i  in  1  1 = write burst, 0 = read burst
- req_addr_i  in  axi_addr_width_p  byte address
- req_ready_o  out  1  request accepted when req_v_i & req_ready_o
- wdata_v_i  in  1  write-data word valid
- wdata_i  in  axi_data_width_p  write word
- wstrb_i  in  axi_strb_width_lp  byte enables
- wdata_ready_o  out  1  write word consumed
- rdata_v_o  out  1  read word valid
- rdata_o  out  axi_data_width_p  read word
- rdata_last_o  out  1  last word of burst
- rdata_ready_i  in  1  read word consumed
- done_v_o  out  1  one-cycle transaction-complete pulse
- done_err_o  out  1  valid with done_v_o; 1 if any nonzero resp or ID mismatch
- AXI master: axi_awid_o, axi_awaddr_o, axi_awburst_o[1:0], axi_awvalid_o, axi_awready_i; axi_wdata_o, axi_wstrb_o, axi_wlast_o, axi_wvalid_o, axi_wready_i; axi_bid_i, axi_bresp_i[1:0], axi_bvalid_i, axi_bready_o; axi_arid_o, axi_araddr_o, axi_arburst_o[1:0], axi_arvalid_o, axi_arready_i; axi_rid_i, axi_rdata_i, axi_rresp_i[1:0], axi_rlast_i, axi_rvalid_i, axi_rready_o.

## Operation
- States: IDLE, WR_ADDR, WR_DATA, WR_RESP, RD_ADDR, RD_DATA. One transaction outstanding.
- IDLE: req_ready_o=1. On accept, register addr (see Configuration), clear beat counter and error flag; go WR_ADDR if req_write_i else RD_ADDR.
- WR_ADDR: axi_awvalid_o=1, awaddr/awid stable; on awready → WR_DATA.
- WR_DATA: axi_wvalid_o=wdata_v_i, wdata_ready_o=axi_wready_i, wdata/wstrb pass through combinationally. Beat counter (width clog2(burst_len), safe for 1) increments per W handshake. axi_wlast_o=(count==axi_burst_len_p-1). Handshake on last beat → WR_RESP.
- WR_RESP: axi_bready_o=1. On bvalid: done_v_o=1, done_err_o=(bresp!=0)|(bid!=axi_id_p); → IDLE.
- RD_ADDR: axi_arvalid_o=1; on arready → RD_DATA.
- RD_DATA: rdata_v_o=axi_rvalid_i, axi_rready_o=rdata_ready_i, rdata_o=axi_rdata_i, rdata_last_o=axi_rlast_i. Error flag ORs (rresp!=0)|(rid!=axi_id_p) per handshake. On handshake with rlast: done_v_o=1, done_err_o=flag|that beat's error; → IDLE.
- Write data arriving before WR_DATA is held off (wdata_ready_o=0).

## Timing
- Reset: state IDLE; all AXI valid/ready outputs 0, req_ready_o 0 during reset cycle then 1 in IDLE; done_v_o 0; registered addr/counter/flag 0.
- Request accept → awvalid/arvalid earliest next cycle. Min write: 1 (AW) + burst_len (W) + 1 (B) cycles after accept with zero-wait slave.
- valid signals never drop before handshake; addr held constant while valid.
- done_v_o and req_ready_o never high in same cycle; new request accepted earliest the cycle after done_v_o.
- Reset mid-burst: immediately returns to IDLE, deasserts all valids; slave side must be reset together.
- axi_burst_len_p=1: wlast high on first beat.

## Configuration
- BSG_AXI_BURST_MASTER_WRAP_EN defined: axi_awburst_o/axi_arburst_o=WRAP (2'b10); address passed through aligned only to data-word size (critical-word-first).
- Undefined: burst type INCR (2'b01); address aligned down to burst boundary (axi_data_width_p/8*axi_burst_len_p bytes).

## Test plan
- data 64, len 4, INCR: write req addr 0x40, words 1..4, strb 0xFF → awaddr 0x40, wlast on 4th beat, done_v_o pulse, done_err_o=0; read 0x40 → 1,2,3,4, rdata_last_o on 4th.
- INCR alignment: read req addr 0x48 → araddr 0x40.
- WRAP_EN: write 0x40..0x58 words A..D, read req 0x50 → araddr 0x50, data C,D,A,B.
- Backpressure: random awready/wready/rready/rdata_ready_i stalls → valids held, addr/data stable, beat count exact, no extra beats.
- Error: slave returns bresp=2'b10 → done_err_o=1; rid=axi_id_p+1 on one beat → done_err_o=1 at last beat.
- Reset asserted on beat 2 of a read → next cycle all valids 0, req_ready_o 1 after reset release.
